magma_timer: RTL and testbench

//   Memory-mapped 64-bit timer that acts as a bus responder (slave) on the magma xbar.
//   It sits on a spare slave port (s5 when the xbar grows; otherwise it replaces gpio on s4).

---
 rtl/magma_timer_if.sv | 23 ++
 rtl/magma_timer.sv | 207 ++++++++++++++++++++
 tb/tb_magma_timer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/magma_timer_if.sv
// Bus bundle between a magma xbar port (master) and a responder such as the
// timer (slave). Requests are accepted in their own cycle; read data returns
// later on bus_resp/bus_rdata.
interface magma_timer_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_resp;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_resp, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_resp, bus_rdata
    );
endinterface

// File: rtl/magma_timer.sv
// Memory-mapped 64-bit timer responder for the magma xbar.
// Prescaled 64-bit counter with compare, optional auto-reload, a sticky
// MATCH flag and a registered level interrupt. Every request is accepted in
// its own cycle; read data returns through a RD_LATENCY-deep pipe.
module magma_timer #(
    parameter int RD_LATENCY = 1,   // legal 1..4
    parameter int PRESC_W    = 16   // legal 1..32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    magma_timer_if.slave bus,
    output logic         irq_o
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_STATUS = 3'd1,
        REG_CNT_LO = 3'd2,
        REG_CNT_HI = 3'd3,
        REG_CMP_LO = 3'd4,
        REG_CMP_HI = 3'd5,
        REG_PRESC  = 3'd6,
        REG_RSVD   = 3'd7
    } reg_sel_e;

    typedef struct packed {
        logic auto_reload;  // bit 2
        logic irq_en;       // bit 1
        logic en;           // bit 0
    } ctrl_t;

    // Byte-enable merge shared by every writable register.
    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return merged;
    endfunction

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    ctrl_t                ctrl_q,   ctrl_d;
    logic                 match_q,  match_d;
    logic [63:0]          cnt_q,    cnt_d;
    logic [63:0]          cmp_q,    cmp_d;
    logic [PRESC_W-1:0]   presc_q,  presc_d;
    logic [PRESC_W-1:0]   pcnt_q,   pcnt_d;
    logic [31:0]          shadow_q, shadow_d;
    logic                 irq_q;

    // Read pipe: valid bits and data words, stage RD_LATENCY-1 drives the bus.
    logic [RD_LATENCY-1:0]       pipe_vld;
    logic [RD_LATENCY-1:0][31:0] pipe_data;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    reg_sel_e    sel;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic        match_set;
    logic [31:0] cur_word;   // present value of the addressed register
    logic [31:0] wr_word;    // cur_word with the write bytes merged in
    logic [31:0] rd_word;    // value returned for a read of sel
    logic        unused_addr;

    assign sel         = reg_sel_e'(bus.bus_addr[4:2]);
    assign wr_en       = bus.bus_req &  bus.bus_we;
    assign rd_en       = bus.bus_req & ~bus.bus_we;
    assign bus.bus_ack = bus.bus_req;
    assign unused_addr = ^{bus.bus_addr[31:5], bus.bus_addr[1:0]};

    // Select the addressed register's current contents and the read value.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        cur_word = '0;
        unique case (sel)
            REG_CTRL:   cur_word = {29'b0, ctrl_q};
            REG_STATUS: cur_word = {31'b0, match_q};
            REG_CNT_LO: cur_word = cnt_q[31:0];
            REG_CNT_HI: cur_word = cnt_q[63:32];
            REG_CMP_LO: cur_word = cmp_q[31:0];
            REG_CMP_HI: cur_word = cmp_q[63:32];
            REG_PRESC:  cur_word = 32'(presc_q);
            REG_RSVD:   cur_word = '0;
        endcase
        wr_word = be_merge(cur_word, bus.bus_wdata, bus.bus_be);
        // CNT_HI reads the snapshot taken by the last CNT_LO read, so a
        // LO-then-HI read pair is coherent even while the counter runs.
        rd_word = (sel == REG_CNT_HI) ? shadow_q : cur_word;
    end

    // Next-state for control, counter, compare, prescaler, status and shadow.
    always_comb begin
        ctrl_d    = ctrl_q;
        match_d   = match_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        shadow_d  = shadow_q;
        match_set = 1'b0;

        // Tick uses the EN value held this cycle, so a CTRL write that
        // clears EN still lets this cycle's tick through.
        tick = ctrl_q.en && (pcnt_q == presc_q);

        if (ctrl_q.en) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
        end

        // A bus write to either counter half overrides the increment and
        // suppresses the compare for that cycle.
        if (wr_en && sel == REG_CNT_LO) begin
            cnt_d[31:0] = wr_word;
        end else if (wr_en && sel == REG_CNT_HI) begin
            cnt_d[63:32] = wr_word;
        end else if (tick) begin
            if (cnt_q == cmp_q) begin
                match_set = 1'b1;
                cnt_d     = ctrl_q.auto_reload ? 64'd0 : cnt_q + 64'd1;
            end else begin
                cnt_d = cnt_q + 64'd1;
            end
        end

        if (wr_en) begin
            unique case (sel)
                REG_CTRL:   ctrl_d = ctrl_t'(wr_word[2:0]);
                REG_CMP_LO: cmp_d[31:0]  = wr_word;
                REG_CMP_HI: cmp_d[63:32] = wr_word;
                REG_PRESC: begin
                    presc_d = wr_word[PRESC_W-1:0];
                    pcnt_d  = '0;
                end
                default: ;
            endcase
        end

        // W1C first, then a same-cycle match re-sets the flag.
        if (wr_en && sel == REG_STATUS && bus.bus_be[0] && bus.bus_wdata[0]) begin
            match_d = 1'b0;
        end
        if (match_set) begin
            match_d = 1'b1;
        end

        if (rd_en && sel == REG_CNT_LO) begin
            shadow_d = cnt_q[63:32];
        end
    end

    // Register bank and registered interrupt level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            ctrl_q   <= '0;
            match_q  <= 1'b0;
            cnt_q    <= '0;
            cmp_q    <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            shadow_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            match_q  <= match_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            shadow_q <= shadow_d;
            irq_q    <= match_q & ctrl_q.irq_en;
        end
    end

    // Read response pipe: data sampled in the ack cycle, shifted RD_LATENCY stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the data stages are reset along with the valid bits; the pipe
        // is tiny and a reset that clears it keeps bus_rdata defined.
        if (rst_i) begin
            pipe_vld  <= '0;
            pipe_data <= '0;
        end else begin
            pipe_vld[0] <= rd_en;
            if (rd_en) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign bus.bus_resp  = pipe_vld[RD_LATENCY-1];
    assign bus.bus_rdata = pipe_vld[RD_LATENCY-1] ? pipe_data[RD_LATENCY-1] : 32'd0;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_magma_timer.sv
// Directed bench for magma_timer. Two instances (RD_LATENCY 1 and 3) see the
// same bus stimulus; each read pushes its expected data and return cycle to
// one scoreboard queue per instance, and a negedge monitor pops and compares.
module tb_magma_timer;

    localparam int PRESC_W = 16;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_CNT_LO = 32'h08;
    localparam logic [31:0] A_CNT_HI = 32'h0C;
    localparam logic [31:0] A_CMP_LO = 32'h10;
    localparam logic [31:0] A_CMP_HI = 32'h14;
    localparam logic [31:0] A_PRESC  = 32'h18;
    localparam logic [31:0] A_RSVD   = 32'h1C;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        logic [31:0] addr;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic irq1;
    logic irq3;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    magma_timer_if bif1 ();
    magma_timer_if bif3 ();

    assign bif3.bus_req   = bif1.bus_req;
    assign bif3.bus_we    = bif1.bus_we;
    assign bif3.bus_addr  = bif1.bus_addr;
    assign bif3.bus_be    = bif1.bus_be;
    assign bif3.bus_wdata = bif1.bus_wdata;

    magma_timer #(.RD_LATENCY(1), .PRESC_W(PRESC_W)) u_dut1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bif1),
        .irq_o (irq1)
    );

    magma_timer #(.RD_LATENCY(3), .PRESC_W(PRESC_W)) u_dut3 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bif3),
        .irq_o (irq3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: inputs change 1 time unit after the active edge.
    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        @(posedge clk_i);
        #1;
        bif1.bus_req   = req;
        bif1.bus_we    = we;
        bif1.bus_addr  = addr;
        bif1.bus_wdata = wdata;
        bif1.bus_be    = be;
    endtask

    task automatic wr_be(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        drive(1'b1, 1'b1, addr, data, be);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b1, addr, data, 4'hF);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        drive(1'b1, 1'b0, addr, 32'd0, 4'h0);
        e.data = exp;
        e.addr = addr;
        e.cyc  = cyc + 1;
        q1.push_back(e);
        e.cyc  = cyc + 3;
        q3.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    endtask

    // Samples the interrupt in the middle of the cycle just driven.
    task automatic chk_irq(input logic exp);
        @(negedge clk_i);
        check("irq_lat1", irq1, exp);
        check("irq_lat3", irq3, exp);
    endtask

    // Response monitor for both instances.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        check("ack_lat1", bif1.bus_ack, bif1.bus_req);
        check("ack_lat3", bif3.bus_ack, bif3.bus_req);

        if (bif1.bus_resp) begin
            if (q1.size() == 0) begin
                check("lat1_unexpected_resp", bif1.bus_resp, 1'b0);
            end else begin
                e = q1.pop_front();
                check($sformatf("lat1_rdata_addr%0h", e.addr), bif1.bus_rdata, e.data);
                check($sformatf("lat1_cycle_addr%0h", e.addr), cyc, e.cyc);
            end
        end else begin
            check("lat1_idle_rdata", bif1.bus_rdata, 32'd0);
        end

        if (bif3.bus_resp) begin
            if (q3.size() == 0) begin
                check("lat3_unexpected_resp", bif3.bus_resp, 1'b0);
            end else begin
                e = q3.pop_front();
                check($sformatf("lat3_rdata_addr%0h", e.addr), bif3.bus_rdata, e.data);
                check($sformatf("lat3_cycle_addr%0h", e.addr), cyc, e.cyc);
            end
        end else begin
            check("lat3_idle_rdata", bif3.bus_rdata, 32'd0);
        end
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] seq3 [15];
        seq3 = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2,
                 32'd2, 32'd3, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0};

        bif1.bus_req   = 1'b0;
        bif1.bus_we    = 1'b0;
        bif1.bus_addr  = '0;
        bif1.bus_wdata = '0;
        bif1.bus_be    = '0;

        // Reset values while reset is held.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_irq_lat1", irq1, 1'b0);
        check("rst_irq_lat3", irq3, 1'b0);
        check("rst_resp_lat1", bif1.bus_resp, 1'b0);
        check("rst_resp_lat3", bif3.bus_resp, 1'b0);
        rst_i = 1'b0;

        // 1: CTRL reads 0 after reset.
        rd(A_CTRL, 32'd0);
        chk_irq(1'b0);
        idle(4);

        // 2: PRESC=0, CMP=5, CTRL=3; EN cleared in the 6th tick cycle.
        wr(A_PRESC, 32'd0);
        wr(A_CMP_LO, 32'd5);
        wr(A_CTRL, 32'h3);          // c
        idle(4);                    // c+1..c+4
        rd(A_STATUS, 32'd0);        // c+5: five ticks, no match yet
        wr(A_CTRL, 32'h2);          // c+6: 6th tick still applied
        rd(A_STATUS, 32'd1);        // c+7
        chk_irq(1'b0);
        rd(A_CNT_LO, 32'd6);        // c+8
        chk_irq(1'b1);
        rd(A_CNT_HI, 32'd0);

        // 3: W1C drops irq, then auto-reload counting with PRESC=2.
        wr(A_CNT_LO, 32'd0);
        wr(A_CMP_LO, 32'd3);
        wr(A_PRESC, 32'd2);
        wr(A_STATUS, 32'd1);        // w
        chk_irq(1'b1);
        idle(1);                    // w+1
        chk_irq(1'b1);
        idle(1);                    // w+2
        chk_irq(1'b0);

        wr(A_CTRL, 32'h7);          // c
        for (int k = 0; k < 15; k++) begin
            rd(A_CNT_LO, seq3[k]);  // c+1..c+15
        end
        chk_irq(1'b1);
        rd(A_STATUS, 32'd1);        // c+16
        wr(A_STATUS, 32'd1);        // c+17
        idle(1);                    // c+18
        chk_irq(1'b1);
        rd(A_CTRL, 32'h7);          // c+19
        chk_irq(1'b0);
        idle(4);                    // c+20..c+23
        wr(A_STATUS, 32'd1);        // c+24: match tick collides with W1C
        rd(A_STATUS, 32'd1);        // c+25: set wins
        wr(A_CTRL, 32'h0);          // c+26
        chk_irq(1'b1);
        rd(A_CNT_LO, 32'd0);        // c+27: reloaded to 0
        wr(A_STATUS, 32'd1);        // c+28
        chk_irq(1'b0);

        // 4: coherent LO/HI pair across a carry, wrap, write-over-tick.
        wr(A_PRESC, 32'd0);
        wr(A_CNT_HI, 32'd0);
        wr(A_CNT_LO, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);          // c
        rd(A_CNT_LO, 32'hFFFF_FFFE);// c+1
        idle(1);                    // c+2
        rd(A_CNT_HI, 32'd0);        // c+3: shadow, live half is already 1
        wr(A_CTRL, 32'h0);          // c+4
        rd(A_CNT_LO, 32'd2);
        rd(A_CNT_HI, 32'd1);

        wr(A_CNT_HI, 32'hFFFF_FFFF);
        wr(A_CNT_LO, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        wr(A_CTRL, 32'h0);          // exactly one tick
        rd(A_CNT_LO, 32'd0);
        rd(A_CNT_HI, 32'd0);

        wr(A_CMP_LO, 32'd0);        // CNT==CMP==0 while the write lands
        wr(A_CTRL, 32'h1);          // c
        wr(A_CNT_LO, 32'h100);      // c+1: write beats tick, no compare
        wr(A_CTRL, 32'h0);          // c+2: one more tick
        rd(A_CNT_LO, 32'h101);
        rd(A_STATUS, 32'd0);

        // 5: back-to-back reads, reserved slot, undecoded address bits.
        wr(A_CTRL, 32'hFFFF_FFFA);
        wr(A_CMP_LO, 32'h1234_5678);
        wr(A_PRESC, 32'hFFFF_ABCD);
        wr(A_RSVD, 32'hDEAD_BEEF);
        rd(A_CTRL, 32'h2);
        rd(A_STATUS, 32'd0);
        rd(A_CMP_LO, 32'h1234_5678);
        rd(A_PRESC, 32'h0000_ABCD);
        rd(A_RSVD, 32'd0);
        rd(A_PRESC | 32'h3, 32'h0000_ABCD);
        rd(A_CTRL | 32'h8000_0000, 32'h2);
        idle(4);

        // 6: byte enables, then reset with a read in flight.
        wr(A_CMP_LO, 32'd0);
        wr_be(A_CMP_LO, 32'hAABB_CCDD, 4'b0010);
        rd(A_CMP_LO, 32'h0000_CC00);
        wr_be(A_CMP_HI, 32'hAABB_CCDD, 4'b1001);
        rd(A_CMP_HI, 32'hAA00_00DD);
        idle(5);

        drive(1'b1, 1'b0, A_CMP_LO, 32'd0, 4'h0);   // response must be dropped
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(2);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(6);
        rd(A_CMP_LO, 32'd0);
        rd(A_CTRL, 32'd0);
        chk_irq(1'b0);
        idle(6);

        check("lat1_queue_drained", 64'(q1.size()), 64'd0);
        check("lat3_queue_drained", 64'(q3.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
